// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe_if
//  Description : Handshake bundle for the pipelined immediate generator.
//                Input side:  in_valid/in_ready, in_instr, in_imm_sel, in_tag
//                Output side: out_valid/out_ready, out_imm, out_tag,
//                             out_illegal
//                master = decode-side driver / result consumer,
//                slave  = the immediate generator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_imm_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_imm_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined immediate generator. Extracts and extends the
//                immediate of a 32-bit instruction to XLEN bits, flags bad
//                encodings, and returns the result one cycle later through a
//                2-entry FIFO whose head drives the outputs from flops.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - imm_gen_pipe_if.slave (input and output handshakes)
//  Parameters  : XLEN (32/64), TAG_W (sideband width),
//                AUTO_SEL (1 = derive select code from the opcode)
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int AUTO_SEL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imm_gen_pipe_if.slave        bus
);

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_I     = 3'b001;
    localparam logic [2:0] SEL_S     = 3'b010;
    localparam logic [2:0] SEL_B     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_J     = 3'b101;
    localparam logic [2:0] SEL_Z     = 3'b110;
    localparam logic [2:0] SEL_SHAMT = 3'b111;

    // FIFO entry layout: {illegal, tag, imm}
    localparam int ENTRY_W = XLEN + TAG_W + 1;

    // ------------------------------------------------------------------
    // Opcode-driven select decode
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [2:0] w_auto_sel;
    logic       w_auto_ill;

    assign w_opcode = bus.in_instr[6:0];
    assign w_funct3 = bus.in_instr[14:12];

    always_comb begin
        w_auto_sel = SEL_NONE;
        w_auto_ill = 1'b0;
        case (w_opcode)
            7'b0010011: w_auto_sel = (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                                     ? SEL_SHAMT : SEL_I;
            7'b0000011,
            7'b1100111,
            7'b0011011: w_auto_sel = SEL_I;
            7'b0100011: w_auto_sel = SEL_S;
            7'b1100011: w_auto_sel = SEL_B;
            7'b0110111,
            7'b0010111: w_auto_sel = SEL_U;
            7'b1101111: w_auto_sel = SEL_J;
            // CSR: immediate forms carry a 5-bit uimm in the rs1 field
            7'b1110011: w_auto_sel = w_funct3[2] ? SEL_Z : SEL_I;
            7'b0110011,
            7'b0111011,
            7'b0001111: w_auto_sel = SEL_NONE;
            default: begin
                w_auto_sel = SEL_NONE;
                w_auto_ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate extraction and extension
    // ------------------------------------------------------------------
    logic [2:0]      w_sel;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;

    assign w_sel = (AUTO_SEL != 0) ? w_auto_sel : bus.in_imm_sel;

    always_comb begin
        w_imm = '0;
        // Compressed (non-32-bit) encodings are flagged regardless of select
        w_ill = ((AUTO_SEL != 0) && w_auto_ill) || (bus.in_instr[1:0] != 2'b11);
        case (w_sel)
            SEL_I:     w_imm = XLEN'($signed(bus.in_instr[31:20]));
            SEL_S:     w_imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
            SEL_B:     w_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                              bus.in_instr[30:25], bus.in_instr[11:8],
                                              1'b0}));
            SEL_U:     w_imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
            SEL_J:     w_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                              bus.in_instr[20], bus.in_instr[30:21],
                                              1'b0}));
            SEL_Z:     w_imm = XLEN'(bus.in_instr[19:15]);
            SEL_SHAMT: begin
                if (XLEN == 64) begin
                    w_imm = XLEN'(bus.in_instr[25:20]);
                end else begin
                    w_imm = XLEN'(bus.in_instr[24:20]);
                    // shamt[5] is reserved on a 32-bit datapath
                    w_ill = w_ill | bus.in_instr[25];
                end
            end
            default:   w_imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO: head_q feeds the outputs, skid_q holds the second entry
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] head_q,      head_d;
    logic [ENTRY_W-1:0] skid_q,      skid_d;
    logic [1:0]         count_q,     count_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_new;

    assign w_push = bus.in_valid && in_ready_q;
    assign w_pop  = out_valid_q && bus.out_ready;
    assign w_new  = {w_ill, bus.in_tag, w_imm};

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (w_push) begin
                    head_d  = w_new;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    // Head leaves and the new entry replaces it in place
                    head_d = w_new;
                end else if (w_push) begin
                    skid_d  = w_new;
                    count_d = 2'd2;
                end else if (w_pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: in_ready_q is low, so only a pop can happen
                if (w_pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
        // Handshake flags are registered functions of the next count, so
        // in_ready never sees out_ready combinationally
        out_valid_d = (count_d != 2'd0);
        in_ready_d  = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            skid_q      <= '0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = head_q[XLEN-1:0];
    assign bus.out_tag     = head_q[XLEN +: TAG_W];
    assign bus.out_illegal = head_q[ENTRY_W-1];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. Three instances
//                (XLEN32/external select, XLEN64/auto select, XLEN32/auto
//                select) share one stimulus stream, so their handshakes move
//                in lockstep and one ordered reference queue serves them all.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_sel;
    logic [4:0]  in_tag;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if_a ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if_b ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if_c ();

    assign if_a.in_valid = in_valid;  assign if_a.in_instr = in_instr;
    assign if_a.in_imm_sel = in_imm_sel; assign if_a.in_tag = in_tag;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;  assign if_b.in_instr = in_instr;
    assign if_b.in_imm_sel = in_imm_sel; assign if_b.in_tag = in_tag;
    assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.in_instr = in_instr;
    assign if_c.in_imm_sel = in_imm_sel; assign if_c.in_tag = in_tag;
    assign if_c.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .AUTO_SEL(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .AUTO_SEL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .AUTO_SEL(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {illegal, 64-bit sign-correct immediate}
    // built arithmetically from the field rules.
    function automatic logic [64:0] ref_model(input logic [31:0] ins,
                                              input logic [2:0] esel,
                                              input int xlen, input bit auto_sel);
        logic [2:0] s;
        logic       ill;
        logic [2:0] f3;
        longint     sx, top, v;
        f3  = ins[14:12];
        s   = esel;
        ill = 1'b0;
        if (auto_sel) begin
            case (ins[6:0])
                7'h13:               s = (f3 == 3'd1 || f3 == 3'd5) ? 3'd7 : 3'd1;
                7'h03, 7'h67, 7'h1B: s = 3'd1;
                7'h23:               s = 3'd2;
                7'h63:               s = 3'd3;
                7'h37, 7'h17:        s = 3'd4;
                7'h6F:               s = 3'd5;
                7'h73:               s = f3[2] ? 3'd6 : 3'd1;
                7'h33, 7'h3B, 7'h0F: s = 3'd0;
                default: begin s = 3'd0; ill = 1'b1; end
            endcase
        end
        if (ins[1:0] != 2'b11) ill = 1'b1;
        sx  = longint'($signed(ins));
        top = sx >>> 31;
        v   = 0;
        case (s)
            3'd1: v = sx >>> 20;
            3'd2: begin v = sx >>> 25; v = v * 32 + longint'(ins[11:7]); end
            3'd3: v = top * 4096 + longint'(ins[7]) * 2048
                      + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd4: begin v = sx >>> 12; v = v * 4096; end
            3'd5: v = top * 1048576 + longint'(ins[19:12]) * 4096
                      + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            3'd6: v = longint'(ins[19:15]);
            3'd7: begin
                if (xlen == 32) begin
                    v = longint'(ins[24:20]);
                    if (ins[25]) ill = 1'b1;
                end else begin
                    v = longint'(ins[25:20]);
                end
            end
            default: v = 0;
        endcase
        return {ill, v};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 14))
            0:  r[6:0] = 7'h13;  1: r[6:0] = 7'h03;  2: r[6:0] = 7'h67;
            3:  r[6:0] = 7'h1B;  4: r[6:0] = 7'h23;  5: r[6:0] = 7'h63;
            6:  r[6:0] = 7'h37;  7: r[6:0] = 7'h17;  8: r[6:0] = 7'h6F;
            9:  r[6:0] = 7'h73; 10: r[6:0] = 7'h33; 11: r[6:0] = 7'h3B;
            12: r[6:0] = 7'h0F;
            default: r[6:0] = 7'($urandom);
        endcase
        if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor (negedge, away from the active edge)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [4:0]  tag;
    } ent_t;

    ent_t       exp_q[$];
    logic [4:0] pop_tags[$];
    int         pop_cyc[$];
    int         cyc    = 0;
    bit         mon_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n && mon_en) begin
            logic [64:0] ra, rb, rc;
            check("a_out_valid", 64'(if_a.out_valid), 64'(exp_q.size() != 0));
            check("b_out_valid", 64'(if_b.out_valid), 64'(exp_q.size() != 0));
            check("c_out_valid", 64'(if_c.out_valid), 64'(exp_q.size() != 0));
            check("a_in_ready",  64'(if_a.in_ready),  64'(exp_q.size() < 2));
            check("b_in_ready",  64'(if_b.in_ready),  64'(exp_q.size() < 2));
            check("c_in_ready",  64'(if_c.in_ready),  64'(exp_q.size() < 2));
            if (exp_q.size() != 0) begin
                ra = ref_model(exp_q[0].instr, exp_q[0].sel, 32, 1'b0);
                rb = ref_model(exp_q[0].instr, exp_q[0].sel, 64, 1'b1);
                rc = ref_model(exp_q[0].instr, exp_q[0].sel, 32, 1'b1);
                check("a_imm", 64'(if_a.out_imm), 64'(ra[31:0]));
                check("b_imm", if_b.out_imm, rb[63:0]);
                check("c_imm", 64'(if_c.out_imm), 64'(rc[31:0]));
                check("a_tag", 64'(if_a.out_tag), 64'(exp_q[0].tag));
                check("b_tag", 64'(if_b.out_tag), 64'(exp_q[0].tag));
                check("c_tag", 64'(if_c.out_tag), 64'(exp_q[0].tag));
                check("a_ill", 64'(if_a.out_illegal), 64'(ra[64]));
                check("b_ill", 64'(if_b.out_illegal), 64'(rb[64]));
                check("c_ill", 64'(if_c.out_illegal), 64'(rc[64]));
            end
            if (if_a.out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pop_tags.push_back(if_a.out_tag);
                pop_cyc.push_back(cyc);
            end
            if (in_valid && if_a.in_ready)
                exp_q.push_back('{instr: in_instr, sel: in_imm_sel, tag: in_tag});
        end
    end

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction from idle; returns at the negedge where it is presented
    task automatic send_one(input logic [31:0] ins, input logic [2:0] sel,
                            input logic [4:0] tag);
        in_instr   = ins;
        in_imm_sel = sel;
        in_tag     = tag;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_sel = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_a_valid", 64'(if_a.out_valid), 64'd0);
        check("rst_b_valid", 64'(if_b.out_valid), 64'd0);
        check("rst_a_imm",   64'(if_a.out_imm), 64'd0);
        check("rst_b_imm",   if_b.out_imm, 64'd0);
        check("rst_a_tag",   64'(if_a.out_tag), 64'd0);
        check("rst_a_ill",   64'(if_a.out_illegal), 64'd0);
        check("rst_a_ready", 64'(if_a.in_ready), 64'd1);
        check("rst_c_ready", 64'(if_c.in_ready), 64'd1);
        mon_en = 1'b1;
        tick();

        // Directed vectors with literal expectations
        send_one(32'hFFF00093, 3'b001, 5'd1);
        check("dir_a_i_imm", 64'(if_a.out_imm), 64'hFFFF_FFFF);
        check("dir_a_i_ill", 64'(if_a.out_illegal), 64'd0);
        tick();
        send_one(32'hFE000EE3, 3'b011, 5'd2);
        check("dir_a_b_imm", 64'(if_a.out_imm), 64'hFFFF_FFFC);
        tick();
        send_one(32'h80000037, 3'b100, 5'd3);
        check("dir_b_lui_imm", if_b.out_imm, 64'hFFFF_FFFF_8000_0000);
        tick();
        send_one(32'h000FD073, 3'b110, 5'd4);
        check("dir_b_csr_imm", if_b.out_imm, 64'h1F);
        tick();
        send_one(32'h03F09093, 3'b111, 5'd5);
        check("dir_b_sh_imm", if_b.out_imm, 64'h3F);
        check("dir_b_sh_ill", 64'(if_b.out_illegal), 64'd0);
        check("dir_a_sh_ill", 64'(if_a.out_illegal), 64'd1);
        tick();
        send_one(32'h02009093, 3'b111, 5'd6);
        check("dir_c_sh_ill", 64'(if_c.out_illegal), 64'd1);
        tick();
        send_one(32'h00000000, 3'b000, 5'd7);
        check("dir_c_op0_imm", 64'(if_c.out_imm), 64'd0);
        check("dir_c_op0_ill", 64'(if_c.out_illegal), 64'd1);
        tick();

        // Backpressure: tags 1,2,3 offered with downstream stalled
        pop_tags.delete();
        pop_cyc.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = rand_instr(); in_imm_sel = 3'($urandom); in_tag = 5'd1;
        tick();
        in_instr  = rand_instr(); in_imm_sel = 3'($urandom); in_tag = 5'd2;
        tick();
        in_instr  = rand_instr(); in_imm_sel = 3'($urandom); in_tag = 5'd3;
        @(negedge clk);
        check("bp_full_ready", 64'(if_a.in_ready), 64'd0);
        check("bp_head_tag",   64'(if_a.out_tag), 64'd1);
        repeat (3) tick();
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = if_a.in_ready;
            tick();
        end
        check("bp_tag3_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
        repeat (4) tick();
        check("bp_pop_count", 64'(pop_tags.size()), 64'd3);
        if (pop_tags.size() == 3) begin
            check("bp_order0", 64'(pop_tags[0]), 64'd1);
            check("bp_order1", 64'(pop_tags[1]), 64'd2);
            check("bp_order2", 64'(pop_tags[2]), 64'd3);
            check("bp_consecutive", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);
        end

        // Streaming: one result per cycle with both sides always ready
        pop_tags.delete();
        pop_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            in_instr   = rand_instr();
            in_imm_sel = 3'($urandom);
            in_tag     = 5'(i);
            in_valid   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("stream_count", 64'(pop_tags.size()), 64'd20);
        if (pop_tags.size() == 20)
            check("stream_span", 64'(pop_cyc[19] - pop_cyc[0]), 64'd19);
        tick();

        // Random traffic on both handshakes
        for (int i = 0; i < 400; i++) begin
            in_instr   = rand_instr();
            in_imm_sel = 3'($urandom);
            in_tag     = 5'($urandom);
            in_valid   = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = rand_instr(); in_tag = 5'd20;
        tick();
        in_instr  = rand_instr(); in_tag = 5'd21;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_pre_valid", 64'(if_a.out_valid), 64'd1);
        check("mid_rst_pre_ready", 64'(if_a.in_ready), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", 64'(if_a.out_valid), 64'd0);
        check("mid_rst_b_valid", 64'(if_b.out_valid), 64'd0);
        check("mid_rst_c_valid", 64'(if_c.out_valid), 64'd0);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(if_a.in_ready), 64'd1);
        check("post_rst_valid", 64'(if_a.out_valid), 64'd0);
        repeat (5) tick();
        send_one(32'h00500113, 3'b001, 5'd9);
        check("post_rst_tag", 64'(if_a.out_tag), 64'd9);
        check("post_rst_imm", 64'(if_a.out_imm), 64'd5);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
